dec2bin_rx: RTL



---
 rtl/dec2bin_pkg.sv | 29 ++
 rtl/dec2bin_if.sv | 32 +++
 rtl/dec2bin_mac10.sv | 31 +++
 rtl/dec2bin_rx.sv | 101 ++++++++++
 4 files changed

// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg: shared constants and types for the ASCII-decimal receiver.
//   DEFAULT_WIDTH      default result width
//   CHAR_0 .. CHAR_LF  ASCII codes the line parser recognises
//   state_t            receiver FSM states
//   is_digit/is_term   byte classification helpers
package dec2bin_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHAR_0) && (b <= CHAR_9);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

endpackage

// File: rtl/dec2bin_if.sv
// dec2bin_if: byte-in / result-out handshake bundle for dec2bin_rx.
//   in_valid/in_data/in_ready        ASCII byte stream from the UART RX
//   out_valid/out_ready              result handshake towards the consumer
//   out_value/out_ovf/out_err/out_digits  result payload
// Modports: master = byte producer and result consumer, slave = converter.
interface dec2bin_if
    import dec2bin_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_ovf;
    logic             out_err;
    logic [2:0]       out_digits;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_value, out_ovf, out_err, out_digits
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_value, out_ovf, out_err, out_digits
    );

endinterface

// File: rtl/dec2bin_mac10.sv
// dec2bin_mac10: combinational acc*10 + d step.
//   acc      current accumulator
//   d        decimal digit 0..9
//   acc_next next accumulator (wrapped, or saturated when DEC2BIN_SAT_EN)
//   ovf      this step's exact result exceeded 2^WIDTH-1
// Build option: DEC2BIN_SAT_EN selects saturation instead of modulo wrap.
module dec2bin_mac10 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       d,
    output logic [WIDTH-1:0] acc_next,
    output logic             ovf
);

    logic [WIDTH+3:0] acc_wide;
    logic [WIDTH+3:0] prod;

    // Four extra bits hold 10*(2^WIDTH-1)+9 exactly.
    assign acc_wide = {4'b0000, acc};
    assign prod     = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, d};
    assign ovf      = |prod[WIDTH+3:WIDTH];

`ifdef DEC2BIN_SAT_EN
    // An all-ones acc overflows again on every later digit, so it stays pinned.
    assign acc_next = ovf ? '1 : prod[WIDTH-1:0];
`else
    assign acc_next = prod[WIDTH-1:0];
`endif

endmodule

// File: rtl/dec2bin_rx.sv
// dec2bin_rx: streaming ASCII-decimal to binary converter.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      dec2bin_if.slave: byte input handshake and result output handshake
// One result per CR/LF-terminated line; blank lines and CRLF pairs produce none.
// Build option: DEC2BIN_SAT_EN (handled in dec2bin_mac10) saturates instead of wrapping.
module dec2bin_rx
    import dec2bin_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    dec2bin_if.slave bus
);

    state_t           state, state_next;
    logic             accept, digit, term;
    logic [WIDTH-1:0] acc, acc_next;
    logic             step_ovf;
    logic             ovf_q, err_q;
    logic [2:0]       dig_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_value_q;
    logic             out_ovf_q, out_err_q;
    logic [2:0]       out_digits_q;

    assign digit  = is_digit(bus.in_data);
    assign term   = is_term(bus.in_data);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = (state != HOLD);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_value  = out_value_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_digits = out_digits_q;

    dec2bin_mac10 #(.WIDTH(WIDTH)) u_mac10 (
        .acc      (acc),
        .d        (bus.in_data[3:0]),
        .acc_next (acc_next),
        .ovf      (step_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && !term) state_next = ACCUM;
            ACCUM:   if (accept && term)  state_next = HOLD;
            HOLD:    if (bus.out_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            dig_q        <= '0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
            out_digits_q <= '0;
        end else if (state == HOLD) begin
            // Line state is kept until hand-off; out_* stay frozen meanwhile.
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                acc         <= '0;
                ovf_q       <= 1'b0;
                err_q       <= 1'b0;
                dig_q       <= '0;
            end
        end else if (accept) begin
            if (digit) begin
                acc   <= acc_next;
                ovf_q <= ovf_q | step_ovf;
                if (dig_q != 3'd7) dig_q <= dig_q + 3'd1;
            end else if (term) begin
                if (state == ACCUM) begin
                    out_valid_q  <= 1'b1;
                    out_value_q  <= acc;
                    out_ovf_q    <= ovf_q;
                    out_err_q    <= err_q;
                    out_digits_q <= dig_q;
                end
            end else begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
